// File: rtl/contador_pulsos.sv
// Rising-edge event counter for an asynchronous input: 2-FF synchronizer,
// optional debounce filter, single-cycle edge detector, wrapping or saturating count.
module contador_pulsos #(
    parameter int ANCHO       = 8,
    parameter int SATURAR     = 0,
    parameter int ANTIRREBOTE = 0
) (
    input  logic             reloj,
    input  logic             rst,
    input  logic             entrada,
    input  logic             habilitar,
    input  logic             limpiar,
    output logic [ANCHO-1:0] contador,
    output logic             desborde,
    output logic             pulso_det
);

    localparam logic [ANCHO-1:0] MAXIMO = '1;

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic             nivel;
    logic [ANCHO-1:0] contador_q, contador_d;
    logic             desborde_q, desborde_d;
    logic             pulso;

    // Synchronizer and edge history reset high so a line already high at release is not counted.
    always_comb begin
        s1_d = entrada;
        s2_d = s1_q;
        s3_d = nivel;
    end

    always_ff @(posedge reloj) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    generate
        if (ANTIRREBOTE == 0) begin : g_directo
            assign nivel = s2_q;
        end else begin : g_filtro
            localparam int CW = (ANTIRREBOTE > 1) ? $clog2(ANTIRREBOTE) : 1;

            logic [CW-1:0] cuenta_q, cuenta_d;
            logic          nivel_q, nivel_d;

            // The level follows s2 only after it has disagreed for ANTIRREBOTE consecutive cycles.
            always_comb begin
                cuenta_d = cuenta_q;
                nivel_d  = nivel_q;
                if (s2_q == nivel_q) begin
                    cuenta_d = '0;
                end else if (cuenta_q == CW'(ANTIRREBOTE - 1)) begin
                    nivel_d  = s2_q;
                    cuenta_d = '0;
                end else begin
                    cuenta_d = cuenta_q + CW'(1);
                end
            end

            always_ff @(posedge reloj) begin
                if (rst) begin
                    cuenta_q <= '0;
                    nivel_q  <= 1'b1;
                end else begin
                    cuenta_q <= cuenta_d;
                    nivel_q  <= nivel_d;
                end
            end

            assign nivel = nivel_q;
        end
    endgenerate

    assign pulso = nivel & ~s3_q;

    // Clear wins over a coincident pulse; a disabled pulse is simply lost.
    always_comb begin
        contador_d = contador_q;
        desborde_d = desborde_q;
        if (limpiar) begin
            contador_d = '0;
            desborde_d = 1'b0;
        end else if (pulso && habilitar) begin
            if (contador_q != MAXIMO) begin
                contador_d = contador_q + 1'b1;
            end else begin
                desborde_d = 1'b1;
                contador_d = (SATURAR != 0) ? MAXIMO : '0;
            end
        end
    end

    always_ff @(posedge reloj) begin
        if (rst) begin
            contador_q <= '0;
            desborde_q <= 1'b0;
        end else begin
            contador_q <= contador_d;
            desborde_q <= desborde_d;
        end
    end

    assign contador  = contador_q;
    assign desborde  = desborde_q;
    assign pulso_det = pulso;

endmodule

// File: tb/tb_contador_pulsos.sv
// Directed bench for contador_pulsos: wrapping, saturating and debounced instances.
module tb_contador_pulsos;

    logic       reloj;
    logic       rst;
    logic       entrada, habilitar, limpiar;
    logic       entrada_d, habilitar_d, limpiar_d;
    logic [7:0] cnt_w, cnt_s, cnt_d;
    logic       desb_w, desb_s, desb_d;
    logic       pd_w, pd_s, pd_d;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       e;
        logic       hab;
        logic       lim;
        logic [7:0] cnt;
        logic       pulso;
    } vec_t;

    vec_t tbl [18];

    contador_pulsos dut_w (
        .reloj(reloj), .rst(rst), .entrada(entrada), .habilitar(habilitar),
        .limpiar(limpiar), .contador(cnt_w), .desborde(desb_w), .pulso_det(pd_w)
    );

    contador_pulsos #(.SATURAR(1)) dut_s (
        .reloj(reloj), .rst(rst), .entrada(entrada), .habilitar(habilitar),
        .limpiar(limpiar), .contador(cnt_s), .desborde(desb_s), .pulso_det(pd_s)
    );

    contador_pulsos #(.ANTIRREBOTE(4)) dut_d (
        .reloj(reloj), .rst(rst), .entrada(entrada_d), .habilitar(habilitar_d),
        .limpiar(limpiar_d), .contador(cnt_d), .desborde(desb_d), .pulso_det(pd_d)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    task automatic step();
        @(posedge reloj);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // One 2-high/2-low pulse on the shared input; i is the pulse's index since the last clear.
    task automatic do_pulse(input int i);
        int exp_w, exp_s, exp_o;
        exp_w = i % 256;
        exp_s = (i > 255) ? 255 : i;
        exp_o = (i >= 256) ? 1 : 0;
        entrada = 1'b1; step();
        entrada = 1'b1; step();
        check("pulse_strobe_w", pd_w, 1);
        check("pulse_strobe_s", pd_s, 1);
        entrada = 1'b0; step();
        check("pulse_cnt_w", cnt_w, exp_w);
        check("pulse_cnt_s", cnt_s, exp_s);
        check("pulse_desb_w", desb_w, exp_o);
        check("pulse_desb_s", desb_s, exp_o);
        check("pulse_strobe_off", pd_w, 0);
        entrada = 1'b0; step();
    endtask

    initial begin
        //                e     hab   lim   cnt   pulso
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'd1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'd1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'd2, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'd2, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'd2, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 8'd2, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 8'd0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0};

        // Reset with inputs high, release with them still high.
        rst = 1'b1;
        entrada = 1'b1; habilitar = 1'b1; limpiar = 1'b0;
        entrada_d = 1'b1; habilitar_d = 1'b1; limpiar_d = 1'b0;
        repeat (3) step();
        check("reset_cnt_w", cnt_w, 0);
        check("reset_desb_w", desb_w, 0);
        check("reset_cnt_s", cnt_s, 0);
        check("reset_cnt_d", cnt_d, 0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            check("idle_strobe_w", pd_w, 0);
            check("idle_strobe_d", pd_d, 0);
            check("idle_cnt_w", cnt_w, 0);
            check("idle_cnt_s", cnt_s, 0);
        end

        // Latency, enable and clear priority table on the shared input.
        for (int v = 0; v < 18; v++) begin
            entrada   = tbl[v].e;
            habilitar = tbl[v].hab;
            limpiar   = tbl[v].lim;
            step();
            check($sformatf("tbl%0d_cnt_w", v), cnt_w, tbl[v].cnt);
            check($sformatf("tbl%0d_cnt_s", v), cnt_s, tbl[v].cnt);
            check($sformatf("tbl%0d_pd_w", v), pd_w, tbl[v].pulso);
            check($sformatf("tbl%0d_desb_w", v), desb_w, 0);
        end
        limpiar = 1'b0;
        habilitar = 1'b1;

        // 260 pulses from zero: wrap at the 256th for dut_w, saturation for dut_s.
        for (int i = 1; i <= 260; i++) do_pulse(i);
        check("end_cnt_w", cnt_w, 4);
        check("end_cnt_s", cnt_s, 255);
        check("end_desb_w", desb_w, 1);
        check("end_desb_s", desb_s, 1);

        limpiar = 1'b1; step();
        limpiar = 1'b0;
        check("clear_cnt_w", cnt_w, 0);
        check("clear_desb_w", desb_w, 0);
        check("clear_cnt_s", cnt_s, 0);
        check("clear_desb_s", desb_s, 0);
        step();
        check("after_clear_cnt_s", cnt_s, 0);
        check("after_clear_desb_s", desb_s, 0);

        // Debounced instance: settle low, then a 2-cycle glitch that must be rejected.
        entrada_d = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check("deb_fall_strobe", pd_d, 0);
        end
        entrada_d = 1'b1; step();
        entrada_d = 1'b1; step();
        entrada_d = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            check("deb_glitch_strobe", pd_d, 0);
            check("deb_glitch_cnt", cnt_d, 0);
        end

        // 10-cycle pulse: strobe after edge k+5, count after edge k+6.
        entrada_d = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            check($sformatf("deb_strobe_j%0d", j), pd_d, (j == 5) ? 1 : 0);
            check($sformatf("deb_cnt_j%0d", j), cnt_d, (j >= 6) ? 1 : 0);
        end
        entrada_d = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step();
            check("deb_low_strobe", pd_d, 0);
            check("deb_low_cnt", cnt_d, 1);
        end
        check("deb_desb", desb_d, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/contador_pulsos.md
Name: contador_pulsos

Overview:
Counts rising edges (pulses) on an asynchronous input `entrada` and presents the running count on `contador`. The input passes through a 2-FF synchronizer and an optional debounce filter. A single-cycle edge detector drives the counter. The block is a front-end event counter for push-buttons or external pulse sources, read by downstream logic or a display.

Parameters:
ANCHO, 8, counter width in bits; `contador` is ANCHO bits.
SATURAR, 0, 0 = wrap from 2^ANCHO-1 to 0; 1 = hold at 2^ANCHO-1.
ANTIRREBOTE, 0, debounce length in clock cycles; 0 = filter bypassed; legal range 0..65535.

Ports:
reloj  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
entrada  input  1  asynchronous pulse input; counted on its rising edges.
habilitar  input  1  count enable; when 0, detected edges are discarded.
limpiar  input  1  synchronous clear of counter and overflow flag.
contador  output  ANCHO  registered pulse count.
desborde  output  1  sticky overflow flag (registered).
pulso_det  output  1  one-cycle strobe per qualified rising edge, independent of habilitar.

Behaviour:
- Reset is synchronous, active-high, and highest priority.
- Reset values:
  - contador = 0, desborde = 0.
  - Synchronizer FFs s1, s2 = 1; history FF s3 = 1; filtered level = 1; debounce counter = 0.
  - Consequence: an `entrada` already high at reset release is not counted. A `entrada` low at release produces no edge.
- Synchronizer: s1 <= entrada; s2 <= s1.
- Filtered level `nivel`:
  - ANTIRREBOTE=0: nivel = s2.
  - ANTIRREBOTE=N>0: internal counter increments while s2 != nivel and resets to 0 when s2 == nivel. When the counter reaches N-1 while s2 != nivel, nivel <= s2 and the counter returns to 0. Glitches shorter than N cycles are rejected.
- Edge detect: s3 <= nivel; pulso_det = nivel & ~s3. pulso_det is high for exactly one cycle per rising edge.
- Latency (ANTIRREBOTE=0): let edge k be the first clock edge that samples entrada=1.
  - pulso_det is high during the cycle after edge k+1.
  - contador shows the new value after edge k+2.
  - Debounce adds ANTIRREBOTE cycles.
- Counter update, priority order per clock edge:
  1. rst: contador = 0, desborde = 0.
  2. limpiar: contador = 0, desborde = 0. A coincident pulse is dropped.
  3. pulso_det & habilitar, contador < max: contador + 1.
  4. pulso_det & habilitar, contador == max:
     - SATURAR=0: contador = 0 and desborde = 1.
     - SATURAR=1: contador holds at max and desborde = 1.
  5. Otherwise: hold.
- desborde stays 1 until rst or limpiar.
- habilitar=0 does not queue pulses; synchronizer and filter keep running.
- Input pulses must be high and low for at least 2 clock cycles each (plus ANTIRREBOTE) to be counted reliably. Shorter pulses may be missed; this is not an error condition.
- Arithmetic is unsigned modulo 2^ANCHO; no X propagation allowed from reset onward.

Test Plan:
- Reset/idle: 10 ns clock, rst=1 for 3 cycles with entrada=1, then release with entrada held at 1 -> contador stays 0, pulso_det never asserts.
- Basic count: habilitar=1; entrada toggles every 20 ns (40 ns period) for 10 rising edges -> contador reads 1..10 in sequence, each increment exactly 2 clock edges after the sampling edge; desborde=0.
- Wrap: SATURAR=0, 257 pulses -> contador goes 255 -> 0 -> 1; desborde=1 from the wrap onward.
- Saturate: SATURAR=1, 260 pulses -> contador holds at 255, desborde=1; then limpiar for 1 cycle -> contador=0, desborde=0.
- Enable/clear priority: habilitar=0 for 3 pulses -> count unchanged; limpiar asserted in the same cycle as pulso_det -> contador=0, pulse not counted.
- Debounce: ANTIRREBOTE=4; a 2-cycle high glitch -> no count; a 10-cycle high pulse -> exactly 1 count, appearing 4 cycles later than with ANTIRREBOTE=0.
